// File: rtl/vec_check_sequencer_pkg.sv
// Shared types for the vector check sequencer: FSM state encoding and the
// per-run verdict record.
package vec_check_pkg;

  localparam int unsigned VCS_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [VCS_CNT_W-1:0] cnt;
    logic [VCS_CNT_W-1:0] fail_cnt;
    logic [VCS_CNT_W-1:0] first_idx;
  } verdict_t;

endpackage

// File: rtl/vec_check_sequencer_if.sv
// Valid/ready vector stream from a vector source (ROM or bench) into the sequencer.
interface vec_check_sequencer_if #(
  parameter int unsigned STIM_W = 9,
  parameter int unsigned OUT_W  = 1
) ();
  logic              vec_valid;
  logic              vec_ready;
  logic [STIM_W-1:0] vec_stim;
  logic [OUT_W-1:0]  vec_exp;
  logic [OUT_W-1:0]  vec_mask;
  logic              vec_last;

  modport master (
    output vec_valid, vec_stim, vec_exp, vec_mask, vec_last,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_stim, vec_exp, vec_mask, vec_last,
    output vec_ready
  );
endinterface

// File: rtl/vec_check_sequencer_settle.sv
// Settle-window down-counter: loaded on the vector handshake, raises zero_o once
// the DUT has had SETTLE full cycles to respond.
module vcs_settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);
  localparam int unsigned     TW       = $clog2(SETTLE + 1);
  localparam logic [TW-1:0]   LOAD_VAL = TW'(SETTLE - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/vec_check_sequencer.sv
// Applies stimulus vectors to a combinational block, samples its output after a
// settle window and keeps masked pass/fail statistics plus a first-failure record.
module vec_check_sequencer
  import vec_check_pkg::*;
#(
  parameter int unsigned STIM_W       = 9,
  parameter int unsigned OUT_W        = 1,
  parameter int unsigned SETTLE       = 2,
  parameter int unsigned CNT_W        = 16,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  vec_check_sequencer_if.slave src,
  output logic [STIM_W-1:0]    dut_stim_o,
  input  logic [OUT_W-1:0]     dut_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 err_pulse_o,
  output logic [CNT_W-1:0]     vec_cnt_o,
  output logic [CNT_W-1:0]     fail_cnt_o,
  output logic [CNT_W-1:0]     first_fail_idx_o,
  output logic [OUT_W-1:0]     first_fail_got_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [STIM_W-1:0]   stim_q, stim_d;
  logic [OUT_W-1:0]    exp_q, exp_d;
  logic [OUT_W-1:0]    mask_q, mask_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]    ff_idx_q, ff_idx_d;
  logic [OUT_W-1:0]    ff_got_q, ff_got_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                err_q, err_d;
  logic                timer_load;
  logic                timer_zero;
  logic                mismatch;

  vcs_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (timer_load),
    .en_i   (state_q == ST_SETTLE),
    .zero_o (timer_zero)
  );

  assign mismatch = |((dut_out_i ^ exp_q) & mask_q);

  always_comb begin
    // NOTE: every next-state value defaults to its held value first, so no branch
    // of the case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    stim_d     = stim_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    last_d     = last_q;
    vec_cnt_d  = vec_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_idx_d   = ff_idx_q;
    ff_got_d   = ff_got_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = 1'b0;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d    = ST_FETCH;
          vec_cnt_d  = '0;
          fail_cnt_d = '0;
          ff_idx_d   = '0;
          ff_got_d   = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      ST_FETCH: begin
        if (src.vec_valid) begin
          stim_d     = src.vec_stim;
          exp_d      = src.vec_exp;
          mask_d     = src.vec_mask;
          last_d     = src.vec_last;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        vec_cnt_d = (vec_cnt_q == CNT_MAX) ? vec_cnt_q : vec_cnt_q + CNT_W'(1);
        if (mismatch) begin
          err_d      = 1'b1;
          fail_cnt_d = (fail_cnt_q == CNT_MAX) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
          if (fail_cnt_q == '0) begin
            ff_idx_d = vec_cnt_q;
            ff_got_d = dut_out_i;
          end
        end
        if (last_q || (mismatch && STOP_ON_FAIL)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_q == '0) && !mismatch;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      stim_q     <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      vec_cnt_q  <= '0;
      fail_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_got_q   <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      vec_cnt_q  <= vec_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_idx_q   <= ff_idx_d;
      ff_got_q   <= ff_got_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
    end
  end

  assign src.vec_ready     = (state_q == ST_FETCH);
  assign busy_o            = (state_q == ST_FETCH) || (state_q == ST_SETTLE) ||
                             (state_q == ST_CHECK);
  assign dut_stim_o        = stim_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_pulse_o       = err_q;
  assign vec_cnt_o         = vec_cnt_q;
  assign fail_cnt_o        = fail_cnt_q;
  assign first_fail_idx_o  = ff_idx_q;
  assign first_fail_got_o  = ff_got_q;
endmodule

// File: tb/tb_vec_check_sequencer.sv
// Runs two sequencers (STOP_ON_FAIL 0 and 1) side by side on the same vector
// lists against a small ternary/mask/shift datapath and a run-level reference model.
module tb_vec_check_sequencer;
  import vec_check_pkg::*;

  localparam int unsigned STIM_W = 9;
  localparam int unsigned OUT_W  = 1;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int          PERIOD = SETTLE + 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic src_rst  = 1'b0;
  logic src_hold = 1'b0;
  int   stall_pct = 0;
  int   n_vec     = 0;

  logic [STIM_W-1:0] v_stim [64];
  logic              v_exp  [64];
  logic              v_mask [64];

  logic [STIM_W-1:0] dut_stim [2];
  logic              dut_out  [2];
  logic              busy [2], done [2], pass [2], err [2], ff_got [2], ready_obs [2];
  logic [CNT_W-1:0]  vec_cnt [2], fail_cnt [2], ff_idx [2];
  int                ptr_obs [2], errs_obs [2];

  verdict_t          exp_v [2];
  logic              exp_got [2];
  int                exp_taken [2];
  logic [STIM_W-1:0] prev_stim [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Combinational block under check: out = wire_0[0]
  function automatic logic dp(input logic [8:0] s);
    logic [7:0] w;
    w = s[8] ? (s[7:0] >> 1) : (s[7:0] & 8'h55);
    return w[0];
  endfunction

  vec_check_sequencer_if #(.STIM_W(STIM_W), .OUT_W(OUT_W)) vif [2] ();

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    int   ptr  = 0;
    int   errs = 0;
    logic hs_q = 1'b0;

    vec_check_sequencer #(
      .STIM_W(STIM_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W),
      .STOP_ON_FAIL(g == 1)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start),
      .src              (vif[g]),
      .dut_stim_o       (dut_stim[g]),
      .dut_out_i        (dut_out[g]),
      .busy_o           (busy[g]),
      .done_o           (done[g]),
      .pass_o           (pass[g]),
      .err_pulse_o      (err[g]),
      .vec_cnt_o        (vec_cnt[g]),
      .fail_cnt_o       (fail_cnt[g]),
      .first_fail_idx_o (ff_idx[g]),
      .first_fail_got_o (ff_got[g])
    );

    assign dut_out[g]   = dp(dut_stim[g]);
    assign ready_obs[g] = vif[g].vec_ready;
    assign ptr_obs[g]   = ptr;
    assign errs_obs[g]  = errs;

    always @(posedge clk) hs_q <= vif[g].vec_valid && vif[g].vec_ready;

    // Vector ROM source: advances one entry per handshake, random stalls.
    always @(negedge clk) begin
      if (src_rst) begin
        ptr  = 0;
        errs = 0;
      end else begin
        if (hs_q) ptr = ptr + 1;
        if (err[g]) errs = errs + 1;
      end
      vif[g].vec_valid = !src_hold && (ptr < n_vec) &&
                         (int'($urandom_range(99)) >= stall_pct);
      vif[g].vec_stim  = v_stim[ptr % 64];
      vif[g].vec_exp   = v_exp[ptr % 64];
      vif[g].vec_mask  = v_mask[ptr % 64];
      vif[g].vec_last  = (ptr == n_vec - 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input string s, input int g);
    return $sformatf("%s[%0d]", s, g);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: walk the vector list with the run rules, stopping where the run ends.
  task automatic model();
    for (int g = 0; g < 2; g++) begin
      verdict_t v;
      logic     mm;
      v = '0;
      exp_got[g]   = 1'b0;
      exp_taken[g] = 0;
      for (int k = 0; k < n_vec; k++) begin
        exp_taken[g]++;
        mm = (dp(v_stim[k]) ^ v_exp[k]) & v_mask[k];
        if (mm) begin
          if (v.fail_cnt == 0) begin
            v.first_idx = VCS_CNT_W'(k);
            exp_got[g]  = dp(v_stim[k]);
          end
          v.fail_cnt++;
        end
        v.cnt++;
        if (mm && (g == 1)) break;
      end
      exp_v[g] = v;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      check(tg({tag, ".busy"}, g), busy[g], 0);
      check(tg({tag, ".done"}, g), done[g], 0);
      check(tg({tag, ".pass"}, g), pass[g], 0);
      check(tg({tag, ".err"}, g), err[g], 0);
      check(tg({tag, ".ready"}, g), ready_obs[g], 0);
      check(tg({tag, ".vec_cnt"}, g), vec_cnt[g], 0);
      check(tg({tag, ".fail_cnt"}, g), fail_cnt[g], 0);
      check(tg({tag, ".ff_idx"}, g), ff_idx[g], 0);
      check(tg({tag, ".ff_got"}, g), ff_got[g], 0);
      check(tg({tag, ".dut_stim"}, g), dut_stim[g], 0);
    end
  endtask

  task automatic run(input string tag, input int hold, input bit chk_lat);
    int lat [2];
    int k;
    tick(); src_rst = 1'b1; src_hold = (hold > 0);
    tick(); src_rst = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int h = 0; h < hold; h++) begin
      for (int g = 0; g < 2; g++) begin
        check(tg({tag, ".hold_ready"}, g), ready_obs[g], 1);
        check(tg({tag, ".hold_stim"}, g), dut_stim[g], prev_stim[g]);
        check(tg({tag, ".hold_busy"}, g), busy[g], 1);
      end
      tick();
    end
    src_hold = 1'b0;
    lat[0] = -1;
    lat[1] = -1;
    k = 0;
    while ((lat[0] < 0 || lat[1] < 0) && k < 4000) begin
      tick();
      k++;
      for (int g = 0; g < 2; g++) if (lat[g] < 0 && done[g]) lat[g] = k;
    end
    model();
    for (int g = 0; g < 2; g++) begin
      check(tg({tag, ".done_seen"}, g), lat[g] >= 0, 1);
      if (chk_lat) check(tg({tag, ".latency"}, g), lat[g], PERIOD * exp_taken[g]);
      check(tg({tag, ".done"}, g), done[g], 1);
      check(tg({tag, ".busy"}, g), busy[g], 0);
      check(tg({tag, ".pass"}, g), pass[g], exp_v[g].fail_cnt == 0);
      check(tg({tag, ".vec_cnt"}, g), vec_cnt[g], exp_v[g].cnt);
      check(tg({tag, ".fail_cnt"}, g), fail_cnt[g], exp_v[g].fail_cnt);
      check(tg({tag, ".ff_idx"}, g), ff_idx[g], exp_v[g].first_idx);
      check(tg({tag, ".ff_got"}, g), ff_got[g], exp_got[g]);
      check(tg({tag, ".err_pulses"}, g), errs_obs[g], exp_v[g].fail_cnt);
      check(tg({tag, ".taken"}, g), ptr_obs[g], exp_taken[g]);
      check(tg({tag, ".dut_stim"}, g), dut_stim[g], v_stim[exp_taken[g] - 1]);
      prev_stim[g] = v_stim[exp_taken[g] - 1];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;

    // Single matching vector
    n_vec = 1; v_stim[0] = {1'b0, 8'hFE}; v_exp[0] = 1'b0; v_mask[0] = 1'b1;
    run("t1", 0, 1'b1);

    // Same vector, wrong expectation
    v_exp[0] = 1'b1;
    run("t2", 0, 1'b1);

    // Four vectors, the third mismatching: continue-on-fail vs stop-on-fail
    n_vec = 4;
    for (int k = 0; k < 4; k++) begin
      v_stim[k] = STIM_W'($urandom);
      v_mask[k] = 1'b1;
      v_exp[k]  = (k == 2) ? ~dp(v_stim[k]) : dp(v_stim[k]);
    end
    run("t3", 0, 1'b1);

    // Source withholds valid for 10 cycles in FETCH
    n_vec = 3;
    for (int k = 0; k < 3; k++) begin
      v_stim[k] = STIM_W'($urandom);
      v_mask[k] = 1'($urandom_range(1));
      v_exp[k]  = 1'($urandom_range(1));
    end
    run("t5", 10, 1'b0);

    // Reset while in SETTLE, then rerun
    n_vec = 1; v_stim[0] = {1'b0, 8'hFE}; v_exp[0] = 1'b0; v_mask[0] = 1'b1;
    tick(); src_rst = 1'b1;
    tick(); src_rst = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int g = 0; g < 2; g++) begin
      check(tg("t6.settle_busy", g), busy[g], 1);
      check(tg("t6.settle_ready", g), ready_obs[g], 0);
    end
    rst_n = 1'b0;
    tick();
    check_zero("t6.rst");
    rst_n = 1'b1;
    run("t6.rerun", 0, 1'b1);

    // Randomized runs with masks, mismatches and source stalls
    for (int r = 0; r < 6; r++) begin
      n_vec     = int'($urandom_range(20, 1));
      stall_pct = int'($urandom_range(50, 0));
      for (int k = 0; k < n_vec; k++) begin
        v_stim[k] = STIM_W'($urandom);
        v_mask[k] = 1'($urandom_range(1));
        v_exp[k]  = ($urandom_range(9) < 2) ? ~dp(v_stim[k]) : dp(v_stim[k]);
      end
      run($sformatf("rnd%0d", r), 0, 1'b0);
    end
    stall_pct = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
